// File: rtl/axi_pkg.sv
// Shared AXI4 definitions: slice modes, default channel payload widths and the
// pack/unpack helpers used by harnesses to flatten channel structs into payload vectors.
package axi_pkg;

    localparam int unsigned AXI_DW = 32;
    localparam int unsigned AXI_IW = 4;
    localparam int unsigned AXI_AW = 32;

    typedef enum logic [1:0] {
        SLICE_BYPASS,
        SLICE_FWD,
        SLICE_FULL
    } slice_mode_e;

    // LEN 8 + SIZE 3 + BURST 2 + LOCK 1 + CACHE 4 + PROT 3 + QOS 4 + REGION 4 = 29
    localparam int unsigned AXI_AW_PW = AXI_IW + AXI_AW + 29;
    localparam int unsigned AXI_W_PW  = AXI_DW + AXI_DW / 8 + 1;
    localparam int unsigned AXI_B_PW  = AXI_IW + 2;
    localparam int unsigned AXI_AR_PW = AXI_AW_PW;
    localparam int unsigned AXI_R_PW  = AXI_IW + AXI_DW + 3;

    typedef struct packed {
        logic [AXI_IW-1:0] id;
        logic [AXI_AW-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
    } axi_ax_t;

    typedef struct packed {
        logic [AXI_DW-1:0]   data;
        logic [AXI_DW/8-1:0] strb;
        logic                last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_IW-1:0] id;
        logic [1:0]        resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_IW-1:0] id;
        logic [AXI_DW-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } axi_r_t;

    // Payload bit order is the struct field order, first field in the MSBs.
    function automatic logic [AXI_AW_PW-1:0] axi_aw_pack(input axi_ax_t ax);
        return ax;
    endfunction

    function automatic axi_ax_t axi_aw_unpack(input logic [AXI_AW_PW-1:0] pld);
        return axi_ax_t'(pld);
    endfunction

    function automatic logic [AXI_AR_PW-1:0] axi_ar_pack(input axi_ax_t ax);
        return ax;
    endfunction

    function automatic axi_ax_t axi_ar_unpack(input logic [AXI_AR_PW-1:0] pld);
        return axi_ax_t'(pld);
    endfunction

    function automatic logic [AXI_W_PW-1:0] axi_w_pack(input axi_w_t w);
        return w;
    endfunction

    function automatic axi_w_t axi_w_unpack(input logic [AXI_W_PW-1:0] pld);
        return axi_w_t'(pld);
    endfunction

    function automatic logic [AXI_B_PW-1:0] axi_b_pack(input axi_b_t b);
        return b;
    endfunction

    function automatic axi_b_t axi_b_unpack(input logic [AXI_B_PW-1:0] pld);
        return axi_b_t'(pld);
    endfunction

    function automatic logic [AXI_R_PW-1:0] axi_r_pack(input axi_r_t r);
        return r;
    endfunction

    function automatic axi_r_t axi_r_unpack(input logic [AXI_R_PW-1:0] pld);
        return axi_r_t'(pld);
    endfunction

endpackage

// File: rtl/axi_skid_buf.sv
// Generic valid/ready pipe stage: bypass wires, single forward register, or
// two-entry fully-registered skid buffer, selected by MODE at elaboration.
module axi_skid_buf
    import axi_pkg::*;
#(
    parameter int unsigned PW   = 1,
    parameter slice_mode_e MODE = SLICE_FULL
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [PW-1:0] in_pld_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [PW-1:0] out_pld_o,
    output logic          busy_o
);

    if (MODE == SLICE_BYPASS) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;

        assign out_valid_o = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign out_pld_o   = in_pld_i;
        assign busy_o      = 1'b0;
    end else if (MODE == SLICE_FWD) begin : g_fwd
        logic          valid_q, valid_d;
        logic [PW-1:0] pld_q, pld_d;
        logic          load;

        assign in_ready_o = rst_ni & (~valid_q | out_ready_i);
        assign load       = in_valid_i & in_ready_o;

        always_comb begin
            valid_d = valid_q;
            pld_d   = pld_q;
            if (load) begin
                valid_d = 1'b1;
                pld_d   = in_pld_i;
            end else if (out_ready_i) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                pld_q   <= '0;
            end else begin
                valid_q <= valid_d;
                pld_q   <= pld_d;
            end
        end

        assign out_valid_o = valid_q;
        assign out_pld_o   = pld_q;
        assign busy_o      = valid_q;
    end else begin : g_full
        logic          main_valid_q, main_valid_d;
        logic          skid_valid_q, skid_valid_d;
        logic          ready_q, ready_d;
        logic [PW-1:0] main_q, main_d;
        logic [PW-1:0] skid_q, skid_d;
        logic          push, pop;

        assign push = in_valid_i & ready_q;
        assign pop  = main_valid_q & out_ready_i;

        // Skid is only ever occupied while main is, so main drains first.
        always_comb begin
            main_valid_d = main_valid_q;
            skid_valid_d = skid_valid_q;
            main_d       = main_q;
            skid_d       = skid_q;
            if (!main_valid_q || pop) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_d       = skid_q;
                    skid_valid_d = push;
                    if (push) begin
                        skid_d = in_pld_i;
                    end
                end else begin
                    main_valid_d = push;
                    if (push) begin
                        main_d = in_pld_i;
                    end
                end
            end else if (push) begin
                skid_valid_d = 1'b1;
                skid_d       = in_pld_i;
            end
            ready_d = ~(main_valid_d & skid_valid_d);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                main_valid_q <= 1'b0;
                skid_valid_q <= 1'b0;
                ready_q      <= 1'b0;
                main_q       <= '0;
                skid_q       <= '0;
            end else begin
                main_valid_q <= main_valid_d;
                skid_valid_q <= skid_valid_d;
                ready_q      <= ready_d;
                main_q       <= main_d;
                skid_q       <= skid_d;
            end
        end

        assign in_ready_o  = ready_q;
        assign out_valid_o = main_valid_q;
        assign out_pld_o   = main_q;
        assign busy_o      = main_valid_q;
    end

endmodule

// File: rtl/axi_reg_slice.sv
// AXI4 register slice: one independently configured pipe stage per channel,
// plus a registered busy flag covering all channels.
module axi_reg_slice
    import axi_pkg::*;
#(
    parameter int unsigned DW      = AXI_DW,
    parameter int unsigned IW      = AXI_IW,
    parameter int unsigned AW      = AXI_AW,
    parameter slice_mode_e AW_MODE = SLICE_FULL,
    parameter slice_mode_e W_MODE  = SLICE_FULL,
    parameter slice_mode_e B_MODE  = SLICE_FWD,
    parameter slice_mode_e AR_MODE = SLICE_FULL,
    parameter slice_mode_e R_MODE  = SLICE_FULL,
    localparam int unsigned AW_PW  = IW + AW + 29,
    localparam int unsigned W_PW   = DW + DW / 8 + 1,
    localparam int unsigned B_PW   = IW + 2,
    localparam int unsigned AR_PW  = AW_PW,
    localparam int unsigned R_PW   = IW + DW + 3
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             s_aw_valid,
    output logic             s_aw_ready,
    input  logic [AW_PW-1:0] s_aw_pld,
    input  logic             s_w_valid,
    output logic             s_w_ready,
    input  logic [W_PW-1:0]  s_w_pld,
    output logic             s_b_valid,
    input  logic             s_b_ready,
    output logic [B_PW-1:0]  s_b_pld,
    input  logic             s_ar_valid,
    output logic             s_ar_ready,
    input  logic [AR_PW-1:0] s_ar_pld,
    output logic             s_r_valid,
    input  logic             s_r_ready,
    output logic [R_PW-1:0]  s_r_pld,
    output logic             m_aw_valid,
    input  logic             m_aw_ready,
    output logic [AW_PW-1:0] m_aw_pld,
    output logic             m_w_valid,
    input  logic             m_w_ready,
    output logic [W_PW-1:0]  m_w_pld,
    input  logic             m_b_valid,
    output logic             m_b_ready,
    input  logic [B_PW-1:0]  m_b_pld,
    output logic             m_ar_valid,
    input  logic             m_ar_ready,
    output logic [AR_PW-1:0] m_ar_pld,
    input  logic             m_r_valid,
    output logic             m_r_ready,
    input  logic [R_PW-1:0]  m_r_pld,
    output logic             busy
);

    logic aw_busy, w_busy, b_busy, ar_busy, r_busy;
    logic busy_q;

    axi_skid_buf #(.PW(AW_PW), .MODE(AW_MODE)) u_aw (
        .clk_i      (ACLK),
        .rst_ni     (ARESETn),
        .in_valid_i (s_aw_valid),
        .in_ready_o (s_aw_ready),
        .in_pld_i   (s_aw_pld),
        .out_valid_o(m_aw_valid),
        .out_ready_i(m_aw_ready),
        .out_pld_o  (m_aw_pld),
        .busy_o     (aw_busy)
    );

    axi_skid_buf #(.PW(W_PW), .MODE(W_MODE)) u_w (
        .clk_i      (ACLK),
        .rst_ni     (ARESETn),
        .in_valid_i (s_w_valid),
        .in_ready_o (s_w_ready),
        .in_pld_i   (s_w_pld),
        .out_valid_o(m_w_valid),
        .out_ready_i(m_w_ready),
        .out_pld_o  (m_w_pld),
        .busy_o     (w_busy)
    );

    // Response channels flow from the m_ side back to the s_ side.
    axi_skid_buf #(.PW(B_PW), .MODE(B_MODE)) u_b (
        .clk_i      (ACLK),
        .rst_ni     (ARESETn),
        .in_valid_i (m_b_valid),
        .in_ready_o (m_b_ready),
        .in_pld_i   (m_b_pld),
        .out_valid_o(s_b_valid),
        .out_ready_i(s_b_ready),
        .out_pld_o  (s_b_pld),
        .busy_o     (b_busy)
    );

    axi_skid_buf #(.PW(AR_PW), .MODE(AR_MODE)) u_ar (
        .clk_i      (ACLK),
        .rst_ni     (ARESETn),
        .in_valid_i (s_ar_valid),
        .in_ready_o (s_ar_ready),
        .in_pld_i   (s_ar_pld),
        .out_valid_o(m_ar_valid),
        .out_ready_i(m_ar_ready),
        .out_pld_o  (m_ar_pld),
        .busy_o     (ar_busy)
    );

    axi_skid_buf #(.PW(R_PW), .MODE(R_MODE)) u_r (
        .clk_i      (ACLK),
        .rst_ni     (ARESETn),
        .in_valid_i (m_r_valid),
        .in_ready_o (m_r_ready),
        .in_pld_i   (m_r_pld),
        .out_valid_o(s_r_valid),
        .out_ready_i(s_r_ready),
        .out_pld_o  (s_r_pld),
        .busy_o     (r_busy)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= aw_busy | w_busy | b_busy | ar_busy | r_busy;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_axi_reg_slice.sv
// Scenario bench for axi_reg_slice: FULL on AW/W/AR, FWD on B, BYPASS on R.
module tb_axi_reg_slice;
    import axi_pkg::*;

    logic ACLK = 1'b0;
    logic ARESETn;

    logic                 s_aw_valid, s_aw_ready;
    logic [AXI_AW_PW-1:0] s_aw_pld;
    logic                 s_w_valid, s_w_ready;
    logic [AXI_W_PW-1:0]  s_w_pld;
    logic                 s_b_valid, s_b_ready;
    logic [AXI_B_PW-1:0]  s_b_pld;
    logic                 s_ar_valid, s_ar_ready;
    logic [AXI_AR_PW-1:0] s_ar_pld;
    logic                 s_r_valid, s_r_ready;
    logic [AXI_R_PW-1:0]  s_r_pld;
    logic                 m_aw_valid, m_aw_ready;
    logic [AXI_AW_PW-1:0] m_aw_pld;
    logic                 m_w_valid, m_w_ready;
    logic [AXI_W_PW-1:0]  m_w_pld;
    logic                 m_b_valid, m_b_ready;
    logic [AXI_B_PW-1:0]  m_b_pld;
    logic                 m_ar_valid, m_ar_ready;
    logic [AXI_AR_PW-1:0] m_ar_pld;
    logic                 m_r_valid, m_r_ready;
    logic [AXI_R_PW-1:0]  m_r_pld;
    logic                 busy;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 ACLK = ~ACLK;

    axi_reg_slice #(.R_MODE(SLICE_BYPASS)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .s_aw_valid(s_aw_valid),
        .s_aw_ready(s_aw_ready),
        .s_aw_pld  (s_aw_pld),
        .s_w_valid (s_w_valid),
        .s_w_ready (s_w_ready),
        .s_w_pld   (s_w_pld),
        .s_b_valid (s_b_valid),
        .s_b_ready (s_b_ready),
        .s_b_pld   (s_b_pld),
        .s_ar_valid(s_ar_valid),
        .s_ar_ready(s_ar_ready),
        .s_ar_pld  (s_ar_pld),
        .s_r_valid (s_r_valid),
        .s_r_ready (s_r_ready),
        .s_r_pld   (s_r_pld),
        .m_aw_valid(m_aw_valid),
        .m_aw_ready(m_aw_ready),
        .m_aw_pld  (m_aw_pld),
        .m_w_valid (m_w_valid),
        .m_w_ready (m_w_ready),
        .m_w_pld   (m_w_pld),
        .m_b_valid (m_b_valid),
        .m_b_ready (m_b_ready),
        .m_b_pld   (m_b_pld),
        .m_ar_valid(m_ar_valid),
        .m_ar_ready(m_ar_ready),
        .m_ar_pld  (m_ar_pld),
        .m_r_valid (m_r_valid),
        .m_r_ready (m_r_ready),
        .m_r_pld   (m_r_pld),
        .busy      (busy)
    );

    function automatic axi_ax_t mk_ax(input logic [31:0] addr);
        axi_ax_t ax;
        ax        = '0;
        ax.id     = addr[5:2];
        ax.addr   = addr;
        ax.size   = 3'd2;
        ax.burst  = 2'd1;
        ax.region = 4'h5;
        return ax;
    endfunction

    task automatic test_reset();
        ARESETn    = 1'b0;
        s_aw_valid = 1'b1;
        s_aw_pld   = axi_aw_pack(mk_ax(32'h55));
        repeat (5) @(posedge ACLK);
        #1;
        chk_cnt++;
        if ({m_aw_valid, m_w_valid, m_ar_valid, s_b_valid} !== 4'b0000)
            $display("FAIL reset_valids: got %b want 0000",
                     {m_aw_valid, m_w_valid, m_ar_valid, s_b_valid});
        else pass_cnt++;
        chk_cnt++;
        if (s_aw_ready !== 1'b0) $display("FAIL reset_aw_ready: got %b want 0", s_aw_ready);
        else pass_cnt++;
        chk_cnt++;
        if (m_b_ready !== 1'b0) $display("FAIL reset_b_ready: got %b want 0", m_b_ready);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;
        chk_cnt++;
        if (m_aw_pld !== '0) $display("FAIL reset_aw_pld: got %h want 0", m_aw_pld);
        else pass_cnt++;
        #2;
        ARESETn = 1'b1;
        #1;
        chk_cnt++;
        if (s_aw_ready !== 1'b0) $display("FAIL release_aw_ready_pre: got %b want 0", s_aw_ready);
        else pass_cnt++;
        chk_cnt++;
        if (m_b_ready !== 1'b1) $display("FAIL release_b_ready: got %b want 1", m_b_ready);
        else pass_cnt++;
        @(posedge ACLK);
        #1;
        chk_cnt++;
        if (s_aw_ready !== 1'b1) $display("FAIL release_aw_ready_edge: got %b want 1", s_aw_ready);
        else pass_cnt++;
        chk_cnt++;
        if (m_aw_valid !== 1'b0) $display("FAIL release_no_aw: got %b want 0", m_aw_valid);
        else pass_cnt++;
        s_aw_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [AXI_W_PW-1:0] exp_q[$];
        logic [AXI_W_PW-1:0] exp;
        axi_w_t w;
        int sent = 0;
        int got = 0;
        int first_out = -1;
        int last_out = -1;
        m_w_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && got < 256; cyc++) begin
            if (sent < 256) begin
                w.data    = sent;
                w.strb    = '1;
                w.last    = (sent == 255);
                s_w_valid = 1'b1;
                s_w_pld   = axi_w_pack(w);
            end else begin
                s_w_valid = 1'b0;
            end
            #2;
            if (m_w_valid) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: got %h want none", m_w_pld);
                end else begin
                    exp = exp_q.pop_front();
                    if (m_w_pld !== exp) $display("FAIL stream_beat%0d: got %h want %h",
                                                  got, m_w_pld, exp);
                    else pass_cnt++;
                end
                got++;
            end
            if (s_w_valid && s_w_ready) begin
                exp_q.push_back(s_w_pld);
                sent++;
            end
            @(posedge ACLK);
            #1;
        end
        s_w_valid = 1'b0;
        chk_cnt++;
        if (got !== 256) $display("FAIL stream_count: got %0d want 256", got);
        else pass_cnt++;
        chk_cnt++;
        if (first_out !== 1) $display("FAIL stream_latency: got %0d want 1", first_out);
        else pass_cnt++;
        chk_cnt++;
        if (last_out !== 256) $display("FAIL stream_gapless: got %0d want 256", last_out);
        else pass_cnt++;
    endtask

    task automatic test_skid();
        logic [31:0] addrs [3];
        logic [AXI_AW_PW-1:0] exp_q[$];
        logic [AXI_AW_PW-1:0] exp;
        int idx = 0;
        int got = 0;
        addrs[0] = 32'h1000;
        addrs[1] = 32'h1004;
        addrs[2] = 32'h1008;
        m_aw_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            s_aw_valid = (idx < 3);
            if (idx < 3) s_aw_pld = axi_aw_pack(mk_ax(addrs[idx]));
            #2;
            if (m_aw_valid) begin
                chk_cnt++;
                if (m_aw_pld !== axi_aw_pack(mk_ax(32'h1000)))
                    $display("FAIL skid_hold: got %h want %h", m_aw_pld,
                             axi_aw_pack(mk_ax(32'h1000)));
                else pass_cnt++;
            end
            if (s_aw_valid && s_aw_ready) begin
                exp_q.push_back(s_aw_pld);
                idx++;
            end
            @(posedge ACLK);
            #1;
        end
        chk_cnt++;
        if (idx !== 2) $display("FAIL skid_absorbed: got %0d want 2", idx);
        else pass_cnt++;
        chk_cnt++;
        if (s_aw_ready !== 1'b0) $display("FAIL skid_full_ready: got %b want 0", s_aw_ready);
        else pass_cnt++;
        m_aw_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
            s_aw_valid = (idx < 3);
            if (idx < 3) s_aw_pld = axi_aw_pack(mk_ax(addrs[idx]));
            #2;
            if (cyc == 1) begin
                chk_cnt++;
                if (s_aw_ready !== 1'b1) $display("FAIL skid_resume_ready: got %b want 1",
                                                  s_aw_ready);
                else pass_cnt++;
            end
            if (m_aw_valid) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL skid_extra: got %h want none", m_aw_pld);
                end else begin
                    exp = exp_q.pop_front();
                    if (m_aw_pld !== exp) $display("FAIL skid_order%0d: got %h want %h",
                                                   got, m_aw_pld, exp);
                    else pass_cnt++;
                end
                got++;
            end
            if (s_aw_valid && s_aw_ready) begin
                exp_q.push_back(s_aw_pld);
                idx++;
            end
            @(posedge ACLK);
            #1;
        end
        s_aw_valid = 1'b0;
        chk_cnt++;
        if (got !== 3) $display("FAIL skid_drain: got %0d want 3", got);
        else pass_cnt++;
    endtask

    task automatic test_fwd_b();
        logic [AXI_B_PW-1:0] exp_q[$];
        logic [AXI_B_PW-1:0] exp;
        logic [31:0] rnd;
        axi_b_t b;
        logic in_fire, out_fire, prev_v, prev_fire;
        int sent = 0;
        int got = 0;
        prev_v    = 1'b0;
        prev_fire = 1'b0;
        m_b_valid = 1'b0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            rnd = $urandom;
            if (!m_b_valid && sent < 1000 && rnd[0]) begin
                b.id      = sent[3:0];
                b.resp    = sent[5:4];
                m_b_valid = 1'b1;
                m_b_pld   = axi_b_pack(b);
            end
            s_b_ready = rnd[1];
            #2;
            if (prev_v && !prev_fire) begin
                chk_cnt++;
                if (s_b_valid !== 1'b1) $display("FAIL b_valid_drop: got %b want 1", s_b_valid);
                else pass_cnt++;
            end
            out_fire = s_b_valid & s_b_ready;
            in_fire  = m_b_valid & m_b_ready;
            if (out_fire) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b_extra: got %h want none", s_b_pld);
                end else begin
                    exp = exp_q.pop_front();
                    if (s_b_pld !== exp) $display("FAIL b_bid%0d: got %h want %h",
                                                  got, s_b_pld, exp);
                    else pass_cnt++;
                end
                got++;
            end
            if (in_fire) begin
                exp_q.push_back(m_b_pld);
                sent++;
            end
            prev_v    = s_b_valid;
            prev_fire = out_fire;
            @(posedge ACLK);
            #1;
            if (in_fire) m_b_valid = 1'b0;
        end
        m_b_valid = 1'b0;
        s_b_ready = 1'b1;
        chk_cnt++;
        if (got !== 1000) $display("FAIL b_count: got %0d want 1000", got);
        else pass_cnt++;
    endtask

    task automatic test_bypass_r();
        logic [31:0] rnd;
        axi_r_t r;
        repeat (4) @(posedge ACLK);
        #1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            rnd       = $urandom;
            r.id      = rnd[3:0];
            r.resp    = rnd[5:4];
            r.last    = rnd[6];
            r.data    = $urandom;
            m_r_valid = rnd[7];
            s_r_ready = rnd[8];
            m_r_pld   = axi_r_pack(r);
            #1;
            chk_cnt++;
            if (s_r_valid !== m_r_valid) $display("FAIL r_valid: got %b want %b",
                                                  s_r_valid, m_r_valid);
            else pass_cnt++;
            chk_cnt++;
            if (s_r_pld !== m_r_pld) $display("FAIL r_pld: got %h want %h", s_r_pld, m_r_pld);
            else pass_cnt++;
            chk_cnt++;
            if (m_r_ready !== s_r_ready) $display("FAIL r_ready: got %b want %b",
                                                  m_r_ready, s_r_ready);
            else pass_cnt++;
            chk_cnt++;
            if (busy !== 1'b0) $display("FAIL r_busy: got %b want 0", busy);
            else pass_cnt++;
            @(posedge ACLK);
            #1;
        end
        m_r_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [AXI_AR_PW-1:0] exp;
        int idx = 0;
        int got = 0;
        m_ar_ready = 1'b0;
        for (int cyc = 0; cyc < 6 && idx < 2; cyc++) begin
            s_ar_valid = 1'b1;
            s_ar_pld   = axi_ar_pack(mk_ax(32'hA0 + 32'(idx * 4)));
            #2;
            if (s_ar_valid && s_ar_ready) idx++;
            @(posedge ACLK);
            #1;
        end
        s_ar_valid = 1'b0;
        chk_cnt++;
        if ({idx == 2, busy, m_ar_valid} !== 3'b111)
            $display("FAIL ar_held: got idx=%0d busy=%b valid=%b want 2/1/1",
                     idx, busy, m_ar_valid);
        else pass_cnt++;
        #2;
        ARESETn = 1'b0;
        #1;
        chk_cnt++;
        if (m_ar_valid !== 1'b0) $display("FAIL ar_async_valid: got %b want 0", m_ar_valid);
        else pass_cnt++;
        chk_cnt++;
        if ({s_ar_ready, busy} !== 2'b00) $display("FAIL ar_async_ready_busy: got %b want 00",
                                                   {s_ar_ready, busy});
        else pass_cnt++;
        repeat (2) @(posedge ACLK);
        #3;
        ARESETn    = 1'b1;
        m_ar_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge ACLK);
            #1;
            chk_cnt++;
            if (m_ar_valid !== 1'b0) $display("FAIL ar_stale: got %b want 0", m_ar_valid);
            else pass_cnt++;
        end
        exp        = axi_ar_pack(mk_ax(32'hB0));
        s_ar_valid = 1'b1;
        s_ar_pld   = exp;
        for (int cyc = 0; cyc < 6 && got < 1; cyc++) begin
            #2;
            if (m_ar_valid) begin
                chk_cnt++;
                if (m_ar_pld !== exp) $display("FAIL ar_fresh: got %h want %h", m_ar_pld, exp);
                else pass_cnt++;
                got++;
            end
            @(posedge ACLK);
            #1;
            s_ar_valid = 1'b0;
        end
        chk_cnt++;
        if (got !== 1) $display("FAIL ar_fresh_count: got %0d want 1", got);
        else pass_cnt++;
    endtask

    initial begin
        ARESETn    = 1'b0;
        s_aw_valid = 1'b0;
        s_aw_pld   = '0;
        s_w_valid  = 1'b0;
        s_w_pld    = '0;
        s_b_ready  = 1'b0;
        s_ar_valid = 1'b0;
        s_ar_pld   = '0;
        s_r_ready  = 1'b0;
        m_aw_ready = 1'b0;
        m_w_ready  = 1'b0;
        m_b_valid  = 1'b0;
        m_b_pld    = '0;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b0;
        m_r_pld    = '0;
        test_reset();
        test_stream();
        test_skid();
        test_fwd_b();
        test_bypass_r();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axi_reg_slice.md
# axi_reg_slice

Parametrised AXI4 register slice that breaks timing paths between an AXI master and an AXI slave on all five channels (AW, W, B, AR, R). Each channel is configured independently as bypass, forward-registered or fully-registered (skid) at elaboration time. The slice is inserted between the testbench master/slave models, or between RTL masters and the interconnect. It is transparent to the protocol: no reordering, no payload modification, and full throughput in every mode.

## Interface
Parameters:
- DW, AXI_DW: data width.
- IW, AXI_IW: ID width.
- AW, AXI_AW: address width.
- AW_MODE, SLICE_FULL: AW channel mode.
- W_MODE, SLICE_FULL: W channel mode.
- B_MODE, SLICE_FWD: B channel mode.
- AR_MODE, SLICE_FULL: AR channel mode.
- R_MODE, SLICE_FULL: R channel mode.

Ports. Clock and reset first. The suffix trio `_valid/_ready/_pld` is in/out/in on the s_ side and out/in/out on the m_ side.
- ACLK  in  1  single clock; all state updates on the rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- s_aw_valid/_ready/_pld  in/out/in  1/1/AW_PW  upstream AW: ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT, QOS, REGION.
- s_w_valid/_ready/_pld  in/out/in  1/1/W_PW  upstream W: DATA, STRB, LAST.
- s_b_valid/_ready/_pld  out/in/out  1/1/B_PW  upstream B: ID, RESP.
- s_ar_valid/_ready/_pld  in/out/in  1/1/AR_PW  upstream AR, same fields as AW.
- s_r_valid/_ready/_pld  out/in/out  1/1/R_PW  upstream R: ID, DATA, RESP, LAST.
- m_aw_*, m_w_*, m_ar_*  out/in/out  downstream request channels.
- m_b_*, m_r_*  in/out/in  downstream response channels.
- busy  out  1  OR of "holds at least one beat" over all channels.

## Operation
- Each channel is a uni-directional valid/ready pipe, from producer to consumer. Request channels run s_ to m_. Response channels run m_ to s_.
- SLICE_BYPASS:
  - Wires: out_valid=in_valid, in_ready=out_ready, out_pld=in_pld.
  - Holds no state and contributes 0 to busy.
- SLICE_FWD:
  - One entry.
  - out_valid and out_pld are registered.
  - in_ready = !out_valid || out_ready (combinational), forced 0 while ARESETn low.
  - Load when in_valid && in_ready.
- SLICE_FULL:
  - Two-entry skid buffer: a main register and a skid register.
  - All outputs are registered: out_valid, out_pld and in_ready.
  - in_ready = (count<2) registered. It drops the cycle after the skid entry fills.
  - A beat accepted while the main register is stalled goes to the skid register.
  - When the main register drains, skid moves to main.
- Ordering is strictly FIFO per channel. No beat is ever dropped or duplicated.
- Payload is passed bit-exact, including all LAST bits.
- Channels are fully independent. There is no cross-channel coupling, e.g. W may precede AW.
- busy is registered OR of per-channel occupancy.

## Timing
- Latency, in_valid to out_valid:
  - BYPASS: 0 cycles.
  - FWD and FULL: 1 cycle.
- Throughput: 1 beat/cycle in every mode under continuous out_ready=1.
- Back-pressure in FULL mode: out_ready low for N cycles with in_valid held high. Exactly 2 beats are absorbed, then in_ready=0. Resuming out_ready gives in_ready=1 the following cycle.
- Simultaneous push and pop:
  - FWD with out_valid=1 and out_ready=1: the new beat replaces the old in the same cycle.
  - FULL with count=1: count stays 1.
- Reset values while ARESETn=0:
  - Every out_valid is 0.
  - Every registered in_ready is 0.
  - All payload registers are 0.
  - busy is 0.
- After reset:
  - FULL in_ready rises on the first ACLK edge after ARESETn deasserts.
  - FWD in_ready is 1 combinationally once reset is released.
- Reset mid-transfer: all held beats are discarded asynchronously. Upstream must also be reset; there is no recovery handshake.
- out_valid, once asserted, is held with a stable payload until out_ready. This must never be violated, including for skid moves.

## Structure
- axi_pkg gains:
  - typedef enum logic [1:0] slice_mode_e {SLICE_BYPASS, SLICE_FWD, SLICE_FULL}.
  - Constants AXI_AW_PW, AXI_W_PW, AXI_B_PW, AXI_AR_PW, AXI_R_PW.
  - Pack/unpack functions per channel.
- Sub-module axi_skid_buf #(PW, MODE): one generic pipe, instantiated five times. The top level is wiring and busy only.
- Existing AXI test interface bundles connect via the pack functions, in the test harness only.

## Test plan
- Reset: hold ARESETn=0 for 5 cycles with s_aw_valid=1 -> all m_*_valid=0, s_aw_ready=0, busy=0; s_aw_ready=1 on the first edge after release (FULL).
- Streaming: 256 W beats with DATA=i and m_w_ready=1 -> m_w_pld sequence 0..255 with LAST on beat 255; gapless, 1-cycle latency.
- Skid fill: AW with ADDR=0x1000, 0x1004, 0x1008, m_aw_ready=0 -> s_aw_ready drops after 2 accepts; on release, order is 0x1000, 0x1004, then 0x1008.
- FWD B mode: random m_b_valid/s_b_ready at 50% -> scoreboard matches all 1000 BIDs in order; s_b_valid never drops without a handshake.
- BYPASS on R: R_MODE=SLICE_BYPASS -> s_r_valid equals m_r_valid in the same cycle, and busy is unaffected by R.
- Mid-burst async reset: assert ARESETn low between clock edges with 2 AR beats held -> m_ar_valid=0 immediately; after release no stale AR beat appears.
